// File: rtl/clk_sel_ctrl.sv
// -----------------------------------------------------------------------------
// clk_sel_ctrl
//
// Generates the select for a downstream glitch-free two-input clock mux.
// Runs on an always-on reference clock. Each candidate clock delivers a
// divide-by-2 toggle that is synchronised and edge-counted over a fixed
// window. A clock is "alive" when its edge count falls inside
// [CNT_MIN, CNT_MAX]. The controller honours software requests, fails over
// automatically away from a dead selected clock, and holds off for SETTLE
// cycles after every change of sel so the mux handshake can complete.
//
// Optional build macro: CLK_SEL_STICKY_EN
//   Adds input fail_clr. An automatic failover sets a sticky lock that
//   freezes sel (no requests, no further failovers) until a fail_clr pulse.
//
// Ports:
//   clk       in   reference clock, always running
//   rst_n     in   asynchronous active-low reset
//   tgl_0     in   divide-by-2 toggle from the clk_0 domain (async)
//   tgl_1     in   divide-by-2 toggle from the clk_1 domain (async)
//   req_sel   in   software-requested source (level)
//   auto_en   in   enables automatic failover
//   fail_clr  in   (CLK_SEL_STICKY_EN only) clears the failover lock
//   sel       out  mux select, 0 = clk_0, 1 = clk_1 (registered)
//   busy      out  switch in progress; requests ignored
//   alive_0   out  clk_0 inside frequency window at last verdict
//   alive_1   out  clk_1 inside frequency window at last verdict
//   fail_irq  out  one-cycle pulse when the selected clock is lost
// -----------------------------------------------------------------------------
module clk_sel_ctrl #(
  parameter int unsigned WIN_LEN     = 200,
  parameter int unsigned WIN_W       = 8,
  parameter int unsigned CNT_MIN     = 40,
  parameter int unsigned CNT_MAX     = 60,
  parameter int unsigned SETTLE      = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tgl_0,
  input  logic tgl_1,
  input  logic req_sel,
  input  logic auto_en,
`ifdef CLK_SEL_STICKY_EN
  input  logic fail_clr,
`endif
  output logic sel,
  output logic busy,
  output logic alive_0,
  output logic alive_1,
  output logic fail_irq
);

  localparam int unsigned WC_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int unsigned ST_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [WC_W-1:0]  WIN_LAST    = WC_W'(WIN_LEN - 1);
  localparam logic [WIN_W-1:0] CNT_LO      = WIN_W'(CNT_MIN);
  localparam logic [WIN_W-1:0] CNT_HI      = WIN_W'(CNT_MAX);
  localparam logic [ST_W-1:0]  SETTLE_LOAD = ST_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_SWITCH,
    S_SETTLE
  } state_t;

  // ---------------------------------------------------------------------------
  // Activity / frequency monitor (independent of the FSM)
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sync [2];
  logic [1:0]             r_last;
  logic [WIN_W-1:0]       r_cnt  [2];
  logic [WC_W-1:0]        r_win;
  logic [1:0]             r_alive;
  logic                   r_fail_irq;

  logic [1:0]             w_tgl;
  logic [1:0]             w_tick;
  logic [1:0]             w_in_win;
  logic [WIN_W-1:0]       w_cnt_inc [2];
  logic                   w_verdict;

  assign w_tgl     = {tgl_1, tgl_0};
  assign w_verdict = (r_win == WIN_LAST);

  // The verdict uses the count including a tick arriving in the verdict cycle,
  // so the saturating increment is formed combinationally and reused both for
  // the counter update and the window comparison.
  always_comb begin
    w_tick   = '0;
    w_in_win = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      w_cnt_inc[i] = r_cnt[i];
    end
    for (int unsigned i = 0; i < 2; i++) begin
      w_tick[i] = r_sync[i][SYNC_STAGES-1] ^ r_last[i];
      if (w_tick[i] && (r_cnt[i] != '1)) begin
        w_cnt_inc[i] = r_cnt[i] + 1'b1;
      end
      w_in_win[i] = (w_cnt_inc[i] >= CNT_LO) && (w_cnt_inc[i] <= CNT_HI);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        r_sync[i] <= '0;
        r_cnt[i]  <= '0;
      end
      r_last     <= '0;
      r_win      <= '0;
      r_alive    <= '0;
      r_fail_irq <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], w_tgl[i]};
        r_last[i] <= r_sync[i][SYNC_STAGES-1];
        r_cnt[i]  <= w_verdict ? '0 : w_cnt_inc[i];
      end
      r_win <= w_verdict ? '0 : r_win + 1'b1;
      if (w_verdict) begin
        r_alive <= w_in_win;
      end
      // Loss of the currently selected clock, independent of auto_en.
      r_fail_irq <= w_verdict && r_alive[r_sel] && !w_in_win[r_sel];
    end
  end

  // ---------------------------------------------------------------------------
  // Selection FSM
  // ---------------------------------------------------------------------------
  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_sel;
  logic             r_busy;
  logic             r_target;
  logic [ST_W-1:0]  r_settle;

  logic             w_fo_cond;
  logic             w_req_cond;
  logic             w_hold;
  logic             w_start;
  logic             w_target;

`ifdef CLK_SEL_STICKY_EN
  logic r_lock;

  // Set only when a failover actually starts (lock clear, rule (a) wins).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock <= 1'b0;
    end else if ((r_state == S_RUN) && !r_lock && w_fo_cond) begin
      r_lock <= 1'b1;
    end else if (fail_clr) begin
      r_lock <= 1'b0;
    end
  end

  assign w_hold = r_lock;
`else
  assign w_hold = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_target    = r_sel;
    w_fo_cond   = auto_en && !r_alive[r_sel] && r_alive[!r_sel];
    w_req_cond  = (req_sel != r_sel) && r_alive[req_sel];

    case (r_state)
      S_RUN: begin
        if (!w_hold) begin
          if (w_fo_cond) begin
            w_start  = 1'b1;
            w_target = !r_sel;
          end else if (w_req_cond) begin
            w_start  = 1'b1;
            w_target = req_sel;
          end
        end
        if (w_start) begin
          w_state_nxt = S_SWITCH;
        end
      end
      S_SWITCH: begin
        w_state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (r_settle == '0) begin
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_RUN;
      r_sel    <= 1'b0;
      r_busy   <= 1'b0;
      r_target <= 1'b0;
      r_settle <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_RUN);
      if (w_start) begin
        r_target <= w_target;
      end
      case (r_state)
        S_SWITCH: begin
          r_sel    <= r_target;
          r_settle <= SETTLE_LOAD;
        end
        S_SETTLE: begin
          if (r_settle != '0) begin
            r_settle <= r_settle - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sel      = r_sel;
  assign busy     = r_busy;
  assign alive_0  = r_alive[0];
  assign alive_1  = r_alive[1];
  assign fail_irq = r_fail_irq;

endmodule

// File: doc/clk_sel_ctrl.md
Name: clk_sel_ctrl

Overview:
Clock-source selection controller that generates the `sel` input of the downstream glitch-free two-input clock mux. Runs on an always-on reference clock. Monitors both candidate clocks for activity and frequency window, honours software switch requests, and performs automatic failover away from a dead or out-of-range clock. Enforces a settle hold-off after every change of `sel` so the mux's cross-domain handshake completes before the next change.

Parameters:
WIN_LEN, 200, monitor window length in clk cycles
WIN_W, 8, width of per-clock edge counters (saturating)
CNT_MIN, 40, minimum edges per window for a clock to be alive
CNT_MAX, 60, maximum edges per window for a clock to be alive
SETTLE, 16, hold-off cycles after `sel` changes
SYNC_STAGES, 2, synchroniser depth for toggle inputs (>=2)

Ports:
clk  input  1  reference clock, always running
rst_n  input  1  asynchronous active-low reset
tgl_0  input  1  divide-by-2 toggle generated in the clk_0 domain; asynchronous to clk
tgl_1  input  1  divide-by-2 toggle generated in the clk_1 domain; asynchronous to clk
req_sel  input  1  software-requested source (level)
auto_en  input  1  enables automatic failover
sel  output  1  mux select (0 = clk_0, 1 = clk_1), registered
busy  output  1  switch in progress; new requests ignored
alive_0  output  1  clk_0 in frequency window at last verdict
alive_1  output  1  clk_1 in frequency window at last verdict
fail_irq  output  1  one-cycle pulse: selected clock lost

Behaviour:
- Interface: single clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values: sel=0, busy=0, alive_0=0, alive_1=0, fail_irq=0. Window counter, edge counters, settle counter and synchroniser flops all 0. FSM enters S_RUN.
- rst_n asserted mid-operation, including during S_SETTLE: every output returns to its reset value immediately.
- Monitor:
  - tgl_x passes through SYNC_STAGES flops.
  - Any change of the last synchroniser stage is one edge tick.
  - The window counter runs 0..WIN_LEN-1 and wraps.
  - Each edge counter increments on its tick and saturates at 2^WIN_W-1.
  - In the cycle where the window counter equals WIN_LEN-1: alive_x <= (CNT_MIN <= edge_cnt_x <= CNT_MAX), using a count that includes a tick in that same cycle. The edge counters then clear to 0.
  - The first verdict occurs WIN_LEN cycles after reset release.
  - The monitor runs independently of the FSM state.
- Target selection in S_RUN, priority order:
  - (a) auto_en=1, alive of current sel is 0 and alive of the other clock is 1: target = ~sel.
  - (b) Otherwise, req_sel != sel and alive[req_sel] = 1: target = req_sel.
  - (c) Otherwise, no action. A request towards a dead clock stays pending with busy=0 and is executed once that clock becomes alive.
  - If both clocks are dead, sel holds.
- FSM states:
  - S_RUN: when a target differs from sel, go to S_SWITCH and set busy=1.
  - S_SWITCH: sel <= target for one cycle; load settle counter with SETTLE-1; go to S_SETTLE.
  - S_SETTLE: decrement the settle counter; at 0 go to S_RUN with busy=0.
  - Latency: req_sel change to busy=1 is 1 cycle; to sel change is 2 cycles. busy stays high for SETTLE+1 cycles in total.
  - req_sel and auto-failover conditions are not evaluated while busy=1. They are re-evaluated in the first S_RUN cycle.
- fail_irq: one-cycle pulse when the alive bit of the currently selected clock falls 1->0 at a window verdict. It fires regardless of auto_en. If the failover switch starts in the same cycle, the pulse still fires.

Optional Feature:
- Macro: CLK_SEL_STICKY_EN.
- When defined:
  - Adds input port `fail_clr` (1 bit).
  - An automatic failover sets an internal sticky lock.
  - While the lock is set, rule (b) and further automatic failovers are suppressed and sel holds.
  - A `fail_clr` pulse clears the lock. The lock resets to 0.
- When undefined: no `fail_clr` port and no lock. Requests back to a recovered clock are honoured as soon as that clock is alive.

Test Plan:
1. Release reset; tgl_0 and tgl_1 both toggle every 4 clk (50 edges per window) -> at cycle 200 alive_0=alive_1=1; sel=0, busy=0, fail_irq never pulses.
2. Both alive, then req_sel 0->1 -> busy=1 next cycle, sel=1 one cycle later, busy falls after 17 cycles high total. Toggling req_sel during busy has no effect.
3. sel=0, auto_en=1, tgl_0 stopped -> at the next verdict alive_0=0, a single fail_irq pulse, then sel=1 two cycles later. With auto_en=0 -> fail_irq pulses and sel stays 0.
4. req_sel=1 with tgl_1 stopped -> sel stays 0, busy=0. Restart tgl_1 -> the switch starts in the cycle after the verdict that sets alive_1=1.
5. tgl_0 toggling every 2 clk (100 edges) -> alive_0=0 (overspeed). Toggling every 10 clk (20 edges) -> alive_0=0 (underspeed).
6. Assert rst_n during S_SETTLE with sel=1 -> sel=0, busy=0, alive_0=0, alive_1=0 without waiting for a clk edge. With CLK_SEL_STICKY_EN defined: after failover, req_sel=0 is ignored until a fail_clr pulse.
